// File: rtl/alu_sched.sv
// alu_sched: round-robin arbiter and sequencer for a shared ALU whose outputs only refresh on an op change.
// Every operation is preceded by a NOP cycle, held EXEC_CYCLES, and its C/Z returned tagged with the requester id.
module alu_sched #(
    parameter int WIDTH       = 16,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [2:0]       req0_op_i,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [2:0]       req1_op_i,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    output logic             rsp_valid_o,
    output logic             rsp_id_o,
    output logic [WIDTH-1:0] rsp_c_o,
    output logic             rsp_z_o,
    output logic             rsp_err_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [2:0]       alu_op_o,
    input  logic [WIDTH-1:0] alu_c_i,
    input  logic             alu_z_i
);

    typedef enum logic [1:0] {IDLE, SETUP, EXEC, RESP} state_e;

    localparam logic [3:0] HOLD_INIT = 4'(EXEC_CYCLES - 1);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [2:0]       op_q, op_d;
    logic             id_q, id_d;
    logic [3:0]       hold_q, hold_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [WIDTH-1:0] rsp_c_q, rsp_c_d;
    logic             rsp_z_q, rsp_z_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_id_q, rsp_id_d;

    logic             gnt0, gnt1, accept, acc_id, acc_legal;
    logic [2:0]       acc_op;
    logic [WIDTH-1:0] acc_a, acc_b;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        gnt0      = req0_valid_i && (!req1_valid_i || last_grant_q);
        gnt1      = req1_valid_i && (!req0_valid_i || !last_grant_q);
        accept    = (state_q == IDLE) && rst_n && (gnt0 || gnt1);
        acc_id    = gnt1;
        acc_op    = gnt1 ? req1_op_i : req0_op_i;
        acc_a     = gnt1 ? req1_a_i  : req0_a_i;
        acc_b     = gnt1 ? req1_b_i  : req0_b_i;
        acc_legal = (acc_op != 3'd0) && (acc_op != 3'd7);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = acc_legal ? SETUP : RESP;
            SETUP:   state_d = EXEC;
            EXEC:    if (hold_q == 4'd0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready_o = (state_q == IDLE) && rst_n && gnt0;
        req1_ready_o = (state_q == IDLE) && rst_n && gnt1;
        alu_op_o     = (state_q == EXEC) ? op_q : 3'd0;
        rsp_valid_o  = (state_q == RESP);
        busy_o       = (state_q != IDLE);
    end

    // Illegal ops never touch the ALU drive; they load their error response directly.
    always_comb begin
        last_grant_d = last_grant_q;
        op_d         = op_q;
        id_d         = id_q;
        hold_d       = hold_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_c_d      = rsp_c_q;
        rsp_z_d      = rsp_z_q;
        rsp_err_d    = rsp_err_q;
        rsp_id_d     = rsp_id_q;
        if (accept) begin
            last_grant_d = acc_id;
            id_d         = acc_id;
            op_d         = acc_op;
            if (acc_legal) begin
                alu_a_d = acc_a;
                alu_b_d = acc_b;
            end else begin
                rsp_c_d   = '0;
                rsp_z_d   = 1'b0;
                rsp_err_d = 1'b1;
                rsp_id_d  = acc_id;
            end
        end
        if (state_q == SETUP) begin
            hold_d = HOLD_INIT;
        end
        if (state_q == EXEC) begin
            if (hold_q == 4'd0) begin
                rsp_c_d   = alu_c_i;
                rsp_z_d   = alu_z_i;
                rsp_err_d = 1'b0;
                rsp_id_d  = id_q;
            end else begin
                hold_d = hold_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            op_q         <= 3'd0;
            id_q         <= 1'b0;
            hold_q       <= 4'd0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_c_q      <= '0;
            rsp_z_q      <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_id_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            id_q         <= id_d;
            hold_q       <= hold_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_c_q      <= rsp_c_d;
            rsp_z_q      <= rsp_z_d;
            rsp_err_q    <= rsp_err_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign alu_a_o   = alu_a_q;
    assign alu_b_o   = alu_b_q;
    assign rsp_c_o   = rsp_c_q;
    assign rsp_z_o   = rsp_z_q;
    assign rsp_err_o = rsp_err_q;
    assign rsp_id_o  = rsp_id_q;

endmodule
